// File: rtl/srio_be_run_splitter.sv
// -----------------------------------------------------------------------------
// srio_be_run_splitter
//
// Takes one bus word (address, data, arbitrary byte enables) and presents it
// downstream as one or more MSB-aligned beats. Each beat's address is advanced
// by the byte offset of its first enabled lane. Its data and enables are
// shifted toward the MSB lane. With SPLIT_RUNS=1, every contiguous run of
// enabled bytes becomes its own beat, so that the SRIO NWRITE builder only
// ever sees contiguous accesses. With SPLIT_RUNS=0, a single beat is emitted
// and any holes in the enables are preserved.
//
// Lane order is big-endian: in_be[BYTES-1] is address offset 0.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/ready    input word handshake
//   in_be             byte enables, one per lane
//   in_addr           byte address of lane BYTES-1
//   in_data           data, byte i = in_data[8i+7:8i]
//   out_valid/ready   output beat handshake
//   out_be            enables of this beat, MSB-aligned
//   out_addr          in_addr + leading offset (wraps modulo 2^ADDR_W)
//   out_data          held data shifted left by 8*offset, zero-filled
//   out_len           bytes in this beat (run length, or span when not splitting)
//   out_last          final beat of the current input word
// -----------------------------------------------------------------------------
module srio_be_run_splitter #(
  parameter int  BYTES      = 8,
  parameter int  ADDR_W     = 32,
  parameter int  SPLIT_RUNS = 1,
  parameter int  DROP_EMPTY = 1,
  localparam int DW         = 8 * BYTES,
  localparam int LW         = $clog2(BYTES) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTES-1:0]  in_be,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DW-1:0]     in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTES-1:0]  out_be,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DW-1:0]     out_data,
  output logic [LW-1:0]     out_len,
  output logic              out_last
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [BYTES-1:0]  mask_q, mask_d;   // enables not yet emitted
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;

  logic hold_valid;
  assign hold_valid = (state_q == BUSY);

  // ---------------------------------------------------------------------------
  // Beat decode from the held mask. The scan starts at the MSB lane (offset 0):
  //   lead_idx - bit index of the first enabled lane
  //   low_idx  - bit index of the last enabled lane
  //   run_mask - contiguous ones starting at lead_idx
  // ---------------------------------------------------------------------------
  logic             found;
  logic             run_done;
  logic [LW-1:0]    lead_idx;
  logic [LW-1:0]    low_idx;
  logic [LW-1:0]    lead_off;
  logic [LW-1:0]    run_len;
  logic [LW-1:0]    span;
  logic [BYTES-1:0] run_mask;

  // NOTE: every variable driven here gets a default before the loop. Otherwise
  // a path that leaves it unassigned would infer a latch.
  always_comb begin
    found    = 1'b0;
    run_done = 1'b0;
    lead_idx = '0;
    low_idx  = '0;
    run_mask = '0;
    for (int i = BYTES - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        if (!found) begin
          found    = 1'b1;
          lead_idx = LW'(i);
        end
        low_idx = LW'(i);
        if (!run_done) begin
          run_mask[i] = 1'b1;
        end
      end else if (found) begin
        run_done = 1'b1;
      end
    end

    run_len = '0;
    for (int i = 0; i < BYTES; i++) begin
      run_len = run_len + LW'(run_mask[i]);
    end

    // An empty mask (possible only when empty words are kept) gives offset 0
    // and length 0, so that word passes through unshifted.
    lead_off = found ? (LW'(BYTES - 1) - lead_idx) : '0;
    span     = found ? (lead_idx - low_idx + LW'(1)) : '0;
  end

  logic [BYTES-1:0] beat_be;
  logic [LW-1:0]    beat_len;
  logic             beat_last;

  always_comb begin
    if (SPLIT_RUNS != 0) begin
      beat_be   = run_mask << lead_off;
      beat_len  = run_len;
      beat_last = ((mask_q & ~run_mask) == '0);
    end else begin
      beat_be   = mask_q << lead_off;
      beat_len  = span;
      beat_last = 1'b1;
    end
  end

  // Outputs are forced to zero whenever nothing is held.
  assign out_valid = hold_valid;
  assign out_be    = hold_valid ? beat_be : '0;
  assign out_addr  = hold_valid ? (addr_q + ADDR_W'(lead_off)) : '0;
  assign out_data  = hold_valid ? (data_q << {lead_off, 3'b000}) : '0;
  assign out_len   = hold_valid ? beat_len : '0;
  assign out_last  = hold_valid & beat_last;

  // A new word may load in the same cycle that the last beat of the current
  // word leaves, so back-to-back words stream without a bubble.
  assign in_ready = !hold_valid || (out_ready && beat_last);

  logic accept;
  logic fire;
  assign accept = in_valid && in_ready;
  assign fire   = hold_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mask_d  = in_be;
          addr_d  = in_addr;
          data_d  = in_data;
          state_d = (DROP_EMPTY != 0 && in_be == '0) ? IDLE : BUSY;
        end
      end
      BUSY: begin
        if (accept) begin
          mask_d  = in_be;
          addr_d  = in_addr;
          data_d  = in_data;
          state_d = (DROP_EMPTY != 0 && in_be == '0) ? IDLE : BUSY;
        end else if (fire) begin
          if (beat_last) begin
            state_d = IDLE;
          end else begin
            mask_d = mask_q & ~run_mask;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_srio_be_run_splitter.sv
// -----------------------------------------------------------------------------
// Testbench for srio_be_run_splitter.
//
// Three instances run side by side:
//   dut 0: split runs, drop empty
//   dut 1: single beat, drop empty
//   dut 2: split runs, keep empty
//
// For each accepted word, a byte-offset reference model pushes the expected
// beats into a per-instance queue. A separate monitor pops and compares each
// beat as it fires. The monitor also checks that stalled beats hold steady and
// that idle outputs stay at zero.
// -----------------------------------------------------------------------------
module tb_srio_be_run_splitter;

  localparam int BYTES  = 8;
  localparam int ADDR_W = 32;
  localparam int DW     = 8 * BYTES;
  localparam int LW     = $clog2(BYTES) + 1;
  localparam int NDUT   = 3;

  // Per-instance configuration, mirrored in the instance parameters below.
  localparam bit CFG_SPLIT [NDUT] = '{1'b1, 1'b0, 1'b1};
  localparam bit CFG_DROP  [NDUT] = '{1'b1, 1'b1, 1'b0};

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BYTES-1:0]  be;
    logic [DW-1:0]     data;
    logic [LW-1:0]     len;
    logic              last;
  } beat_t;

  logic              clk;
  logic              rst_n;
  logic              in_valid  [NDUT];
  logic              in_ready  [NDUT];
  logic [BYTES-1:0]  in_be     [NDUT];
  logic [ADDR_W-1:0] in_addr   [NDUT];
  logic [DW-1:0]     in_data   [NDUT];
  logic              out_valid [NDUT];
  logic              out_ready [NDUT];
  logic [BYTES-1:0]  out_be    [NDUT];
  logic [ADDR_W-1:0] out_addr  [NDUT];
  logic [DW-1:0]     out_data  [NDUT];
  logic [LW-1:0]     out_len   [NDUT];
  logic              out_last  [NDUT];

  int vectors     = 0;
  int miscompares = 0;

  beat_t exp_q [NDUT][$];

  // out_ready control: override wins, else random or constant high.
  bit rdy_ovr  [NDUT];
  bit rdy_val  [NDUT];
  bit rdy_rand [NDUT];

  srio_be_run_splitter #(.BYTES(BYTES), .ADDR_W(ADDR_W), .SPLIT_RUNS(1), .DROP_EMPTY(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_be(in_be[0]),
    .in_addr(in_addr[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_be(out_be[0]),
    .out_addr(out_addr[0]), .out_data(out_data[0]), .out_len(out_len[0]),
    .out_last(out_last[0])
  );

  srio_be_run_splitter #(.BYTES(BYTES), .ADDR_W(ADDR_W), .SPLIT_RUNS(0), .DROP_EMPTY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_be(in_be[1]),
    .in_addr(in_addr[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_be(out_be[1]),
    .out_addr(out_addr[1]), .out_data(out_data[1]), .out_len(out_len[1]),
    .out_last(out_last[1])
  );

  srio_be_run_splitter #(.BYTES(BYTES), .ADDR_W(ADDR_W), .SPLIT_RUNS(1), .DROP_EMPTY(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_be(in_be[2]),
    .in_addr(in_addr[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_be(out_be[2]),
    .out_addr(out_addr[2]), .out_data(out_data[2]), .out_len(out_len[2]),
    .out_last(out_last[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model. It walks byte offsets (offset 0 = in_be[BYTES-1]),
  // collects runs of enabled bytes, and then builds beats from them.
  task automatic model_push(input int g, input logic [BYTES-1:0] be,
                            input logic [ADDR_W-1:0] addr, input logic [DW-1:0] data);
    int    starts [$];
    int    lens   [$];
    int    off;
    int    s;
    int    first;
    int    final_off;
    beat_t b;
    logic [BYTES-1:0] ones;
    ones = '1;
    if (be == '0) begin
      if (!CFG_DROP[g]) begin
        b = '{addr: addr, be: '0, data: data, len: '0, last: 1'b1};
        exp_q[g].push_back(b);
      end
      return;
    end
    off = 0;
    while (off < BYTES) begin
      if (be[BYTES-1-off]) begin
        s = off;
        while (off < BYTES && be[BYTES-1-off]) off++;
        starts.push_back(s);
        lens.push_back(off - s);
      end else begin
        off++;
      end
    end
    if (CFG_SPLIT[g]) begin
      for (int r = 0; r < starts.size(); r++) begin
        b.addr = addr + ADDR_W'(starts[r]);
        b.be   = ~(ones >> lens[r]);
        b.data = data << (8 * starts[r]);
        b.len  = LW'(lens[r]);
        b.last = (r == starts.size() - 1);
        exp_q[g].push_back(b);
      end
    end else begin
      first     = starts[0];
      final_off = starts[starts.size()-1] + lens[lens.size()-1] - 1;
      b.addr = addr + ADDR_W'(first);
      b.be   = be << first;
      b.data = data << (8 * first);
      b.len  = LW'(final_off - first + 1);
      b.last = 1'b1;
      exp_q[g].push_back(b);
    end
  endtask

  // Present one word and wait for it to be accepted. The task is entered
  // shortly after a rising edge and returns shortly after the accepting edge.
  task automatic send(input int g, input logic [BYTES-1:0] be,
                      input logic [ADDR_W-1:0] addr, input logic [DW-1:0] data,
                      output int waited);
    in_valid[g] = 1'b1;
    in_be[g]    = be;
    in_addr[g]  = addr;
    in_data[g]  = data;
    waited      = 0;
    @(negedge clk);
    while (!in_ready[g]) begin
      if (waited >= 200) begin
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout dut%0d: in_ready stayed low for %0d cycles, required high", g, waited);
        in_valid[g] = 1'b0;
        return;
      end
      waited++;
      @(negedge clk);
    end
    model_push(g, be, addr, data);
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
  endtask

  task automatic drain(input int g);
    int n = 0;
    while (exp_q[g].size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check($sformatf("drain_pending dut%0d", g), exp_q[g].size(), 0);
    check($sformatf("drain_idle dut%0d", g), out_valid[g], 1'b0);
  endtask

  // out_ready driver, offset from the edge so that main-thread updates made
  // at +1 take effect in the same cycle.
  initial begin
    for (int g = 0; g < NDUT; g++) out_ready[g] = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      for (int g = 0; g < NDUT; g++) begin
        out_ready[g] = rdy_ovr[g] ? rdy_val[g]
                     : (rdy_rand[g] ? ($urandom_range(0, 3) != 0) : 1'b1);
      end
    end
  end

  // Monitor: sample on the falling edge, away from the active edge.
  initial begin
    bit    prev_stall [NDUT];
    beat_t prev_beat  [NDUT];
    beat_t cur;
    beat_t exp;
    forever begin
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        cur = '{addr: out_addr[g], be: out_be[g], data: out_data[g],
                len: out_len[g], last: out_last[g]};
        if (!rst_n) begin
          prev_stall[g] = 1'b0;
        end else begin
          if (!out_valid[g]) begin
            check($sformatf("idle_zero dut%0d", g), cur, '0);
          end
          check($sformatf("in_ready_rule dut%0d", g), in_ready[g],
                !out_valid[g] || (out_ready[g] && out_last[g]));
          if (prev_stall[g]) begin
            check($sformatf("stall_stable_valid dut%0d", g), out_valid[g], 1'b1);
            check($sformatf("stall_stable_beat dut%0d", g), cur, prev_beat[g]);
          end
          if (out_valid[g] && out_ready[g]) begin
            if (exp_q[g].size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected_beat dut%0d: got addr %0h be %0h, required no beat",
                       g, cur.addr, cur.be);
            end else begin
              exp = exp_q[g].pop_front();
              check($sformatf("beat_addr dut%0d", g), cur.addr, exp.addr);
              check($sformatf("beat_be dut%0d", g),   cur.be,   exp.be);
              check($sformatf("beat_data dut%0d", g), cur.data, exp.data);
              check($sformatf("beat_len dut%0d", g),  cur.len,  exp.len);
              check($sformatf("beat_last dut%0d", g), cur.last, exp.last);
            end
          end
          prev_stall[g] = out_valid[g] && !out_ready[g];
          prev_beat[g]  = cur;
        end
      end
    end
  end

  initial begin
    int w;
    logic [BYTES-1:0]  be;
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     data;

    rst_n = 1'b0;
    for (int g = 0; g < NDUT; g++) begin
      in_valid[g] = 1'b0;
      in_be[g]    = '0;
      in_addr[g]  = '0;
      in_data[g]  = '0;
      rdy_ovr[g]  = 1'b0;
      rdy_val[g]  = 1'b1;
      rdy_rand[g] = 1'b0;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++) check($sformatf("reset_out_valid dut%0d", g), out_valid[g], 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) check($sformatf("reset_in_ready dut%0d", g), in_ready[g], 1'b1);
    @(posedge clk);
    #1;

    // Two-run word: split on dut 0 and dut 2, single beat on dut 1.
    send(0, 8'b0011_0110, 32'h1000, 64'h0011223344556677, w);
    @(negedge clk);
    check("in_ready_low_beat1 dut0", in_ready[0], 1'b0);
    @(posedge clk);
    #1;
    drain(0);
    send(1, 8'b0011_0110, 32'h1000, 64'h0011223344556677, w);
    drain(1);
    send(2, 8'b0011_0110, 32'h1000, 64'h0011223344556677, w);
    drain(2);

    // Back-to-back full-enable words: each must be accepted without a wait.
    for (int i = 0; i < 6; i++) begin
      send(0, 8'hFF, 32'h2000 + ADDR_W'(8 * i), {$urandom, $urandom}, w);
      if (i > 0) check("b2b_no_bubble dut0", w, 0);
    end
    drain(0);

    // Empty word: dropped on dut 0/1, passed through as one beat on dut 2.
    send(0, 8'h00, 32'h3000, 64'hDEADBEEF01234567, w);
    drain(0);
    send(2, 8'h00, 32'h3000, 64'hDEADBEEF01234567, w);
    drain(2);

    // Stall on beat 1 of a three-run word for five cycles.
    rdy_ovr[0] = 1'b1;
    rdy_val[0] = 1'b0;
    @(posedge clk);
    #1;
    send(0, 8'b1010_0001, 32'h4000, 64'h8877665544332211, w);
    check("stall_valid dut0", out_valid[0], 1'b1);
    repeat (5) @(posedge clk);
    #1;
    rdy_ovr[0] = 1'b0;
    drain(0);

    // Address wrap.
    send(0, 8'b0000_0100, 32'hFFFF_FFFE, 64'h0102030405060708, w);
    drain(0);

    // Randomised traffic with random backpressure on every instance.
    for (int g = 0; g < NDUT; g++) begin
      rdy_rand[g] = 1'b1;
      for (int n = 0; n < 150; n++) begin
        case ($urandom_range(0, 9))
          0:       be = 8'h00;
          1:       be = 8'hFF;
          default: be = BYTES'($urandom);
        endcase
        addr = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom)
                                           : 32'hFFFF_FFF8 + ADDR_W'($urandom_range(0, 7));
        data = {$urandom, $urandom};
        send(g, be, addr, data, w);
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
      rdy_rand[g] = 1'b0;
      drain(g);
    end

    // Reset in the middle of a split word: the beat must vanish at once.
    rdy_ovr[0] = 1'b1;
    rdy_val[0] = 1'b0;
    @(posedge clk);
    #1;
    send(0, 8'b0011_0110, 32'h5000, 64'h0011223344556677, w);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid dut0", out_valid[0], 1'b0);
    check("midreset_out_be dut0", out_be[0], '0);
    exp_q[0].delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_ovr[0] = 1'b0;
    @(negedge clk);
    check("postreset_in_ready dut0", in_ready[0], 1'b1);
    check("postreset_out_valid dut0", out_valid[0], 1'b0);
    @(posedge clk);
    #1;
    send(0, 8'b0110_0011, 32'h6000, 64'hA1B2C3D4E5F60718, w);
    drain(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
